vending_machine_multi: RTL
==========================

# vending_machine_multi

Parametrised multi-item vending controller, the successor to the fixed two-product, hard-coded-price machine. It supports NUM_ITEMS products with per-item prices and per-item stock counters, and accepts 1/2/5/10 coins into a credit accumulator. It also supports cancel/refund and restocking. Change is dispensed as a serial coin stream, one coin per cycle, greedy largest-first. It sits between the coin acceptor / keypad front end and the dispenser and coin-hopper drivers.

## Interface
- NUM_ITEMS, 4, number of products; selectable indices 0..NUM_ITEMS-1
- SEL_W, 2, width of item index; 2^SEL_W ≥ NUM_ITEMS
- PRICE_W, 4, width of one price field
- PRICES, {4'd7,4'd5,4'd3,4'd2}, packed prices; item i price = PRICES[i*PRICE_W +: PRICE_W]; every price ≥ 1
- STOCK_W, 4, width of each stock counter
- STOCK_INIT, 3, stock of every item after reset
- CREDIT_W, 5, credit width; 2^CREDIT_W > max price + 9 (no overflow possible)

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin a transaction with item `sel` (sampled in IDLE only)
- sel  in  SEL_W  item index; values ≥ NUM_ITEMS are treated as sold out
- coin_valid  in  1  one coin presented this cycle
- coins  in  2  coin value: 00=1, 01=2, 10=5, 11=10
- cancel  in  1  abort the purchase and refund credit (COLLECT only)
- restock  in  1  add one unit to stock[restock_sel]
- restock_sel  in  SEL_W  item to restock
- done  out  1  vend pulse, high for exactly one cycle
- product  out  SEL_W  item being vended; valid while done=1, else 0
- sold_out  out  1  one-cycle pulse: the requested item has zero stock or is invalid
- credit  out  CREDIT_W  current credit (registered)
- change_valid  out  1  one change coin is dispensed this cycle
- change_coin  out  2  change coin value: 00=1, 01=2, 10=5; 0 when change_valid=0
- busy  out  1  state ≠ IDLE

## Operation
- States:
  - IDLE: credit=0.
    - start=1 with stock[sel]>0 and sel<NUM_ITEMS: latch sel_r and go to COLLECT.
    - start=1 with stock[sel]==0 or sel invalid: register sold_out=1 for one cycle and stay in IDLE.
  - COLLECT: coin_valid adds the coin value to credit; `coins` is ignored when coin_valid=0.
    - cancel=1: go to REFUND if the updated credit is >0, else go to IDLE.
    - Otherwise, if the updated credit ≥ price[sel_r], go to VEND.
    - Coin plus cancel in the same cycle: the coin is accepted and included in the refund.
  - VEND: one cycle. done=1, product=sel_r.
    - stock[sel_r] -= 1 and credit -= price[sel_r].
    - Go to CHANGE if the remaining credit is >0, else go to IDLE.
  - CHANGE / REFUND: share datapath, differ only in entry path. Each cycle:
    - change_valid=1.
    - change_coin = 5 if credit≥5, else 2 if credit≥2, else 1.
    - credit -= coin value.
    - Go to IDLE when credit reaches 0.
- Inputs that are ignored:
  - coin_valid outside COLLECT.
  - start outside IDLE.
  - cancel outside COLLECT.
- Restock is accepted in any state.
  - stock saturates at 2^STOCK_W−1.
  - Restock and vend decrement on the same item in the same cycle: net change 0.
- Arithmetic is unsigned. The CREDIT_W sizing guarantees no wrap.
- Reset (asynchronous, any state, including mid-change):
  - state=IDLE, credit=0, every stock counter=STOCK_INIT.
  - done, product, sold_out, change_valid, change_coin, busy all 0.
  - An interrupted change stream is abandoned, not resumed.

## Timing
- start at edge t in IDLE → busy=1 from t+1.
- sold_out pulse occupies the cycle after the start edge.
- Coin sampled at edge t:
  - credit reflects it from t+1.
  - If the price is reached, done=1 during the cycle starting at t+1.
- First change coin is in the cycle after done. Then one coin per cycle, no gaps.
- Back-to-back transactions: start is accepted in the first IDLE cycle after the last change coin.
- Outputs derive combinationally from registered state/credit/sel_r only (Moore). There is no input-to-output path.
- change_valid, done and sold_out are never high in the same cycle.

## Test plan
- Exact pay: reset; start sel=1 (price 3); coins 2 then 1 → done=1, product=1 one cycle after the second coin; no change_valid; stock[1]=2; back to IDLE.
- Overpay with change: start sel=3 (price 7); coins 5, 5 → done, credit 3, then change_coin 2, then 1 on consecutive cycles → IDLE, credit 0.
- Single big coin: start sel=2 (price 5); coin 10 → done, then one change coin of 5.
- Cancel/refund: start sel=3; coin 2; coin 1 with cancel=1 in the same cycle → no done; refund coins 2, 1.
- Sold out / restock: vend item 0 three times; fourth start sel=0 → sold_out pulse, busy stays 0. Then restock_sel=0 → next purchase vends normally.
- Async reset mid-change: assert rst between the two change coins of the overpay case → change_valid and busy drop immediately (no clock edge needed); credit=0; all stock=3.

Source files
------------

// File: rtl/vending_machine_multi.sv
// Multi-item vending controller: per-item prices and stock, coin credit accumulation,
// cancel/refund, restocking, and greedy serial change output (Moore outputs).
module vending_machine_multi #(
  parameter int                             NUM_ITEMS  = 4,
  parameter int                             SEL_W      = 2,
  parameter int                             PRICE_W    = 4,
  parameter logic [NUM_ITEMS*PRICE_W-1:0]   PRICES     = {4'd7, 4'd5, 4'd3, 4'd2},
  parameter int                             STOCK_W    = 4,
  parameter int                             STOCK_INIT = 3,
  parameter int                             CREDIT_W   = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [SEL_W-1:0]    sel,
  input  logic                coin_valid,
  input  logic [1:0]          coins,
  input  logic                cancel,
  input  logic                restock,
  input  logic [SEL_W-1:0]    restock_sel,
  output logic                done,
  output logic [SEL_W-1:0]    product,
  output logic                sold_out,
  output logic [CREDIT_W-1:0] credit,
  output logic                change_valid,
  output logic [1:0]          change_coin,
  output logic                busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_VEND,
    S_CHANGE,
    S_REFUND
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [CREDIT_W-1:0]  r_credit, w_credit_nxt, w_credit_upd, w_change_val, w_price;
  logic [SEL_W-1:0]     r_sel;
  logic                 r_sold_out, w_sold_nxt, w_avail, w_accept;
  logic [STOCK_W-1:0]   r_stock [NUM_ITEMS];

  function automatic logic [CREDIT_W-1:0] f_coin_val(input logic [1:0] code);
    case (code)
      2'b00:   return CREDIT_W'(1);
      2'b01:   return CREDIT_W'(2);
      2'b10:   return CREDIT_W'(5);
      default: return CREDIT_W'(10);
    endcase
  endfunction

  // Greedy largest-first; the code shares the coin encoding so f_coin_val maps it back.
  function automatic logic [1:0] f_change_code(input logic [CREDIT_W-1:0] c);
    if (c >= CREDIT_W'(5))      return 2'b10;
    else if (c >= CREDIT_W'(2)) return 2'b01;
    else                        return 2'b00;
  endfunction

  function automatic logic [STOCK_W-1:0] f_sat_inc(input logic [STOCK_W-1:0] s);
    return (s == '1) ? s : s + 1'b1;
  endfunction

  always_comb begin
    w_avail = 1'b0;
    w_price = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (sel == SEL_W'(i))   w_avail = (r_stock[i] != '0);
      if (r_sel == SEL_W'(i)) w_price = CREDIT_W'(PRICES[i*PRICE_W +: PRICE_W]);
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_credit_nxt = r_credit;
    w_sold_nxt   = 1'b0;
    w_accept     = 1'b0;
    w_credit_upd = r_credit + (coin_valid ? f_coin_val(coins) : '0);
    w_change_val = f_coin_val(f_change_code(r_credit));
    case (r_state)
      S_IDLE: begin
        w_credit_nxt = '0;
        if (start) begin
          if (w_avail) begin
            w_accept    = 1'b1;
            w_state_nxt = S_COLLECT;
          end else begin
            w_sold_nxt  = 1'b1;
          end
        end
      end
      S_COLLECT: begin
        w_credit_nxt = w_credit_upd;
        if (cancel)                     w_state_nxt = (w_credit_upd != '0) ? S_REFUND : S_IDLE;
        else if (w_credit_upd >= w_price) w_state_nxt = S_VEND;
      end
      S_VEND: begin
        w_credit_nxt = r_credit - w_price;
        w_state_nxt  = (w_credit_nxt != '0) ? S_CHANGE : S_IDLE;
      end
      S_CHANGE, S_REFUND: begin
        w_credit_nxt = r_credit - w_change_val;
        if (w_credit_nxt == '0) w_state_nxt = S_IDLE;
      end
      default: begin
        w_credit_nxt = '0;
        w_state_nxt  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_credit   <= '0;
      r_sel      <= '0;
      r_sold_out <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_credit   <= w_credit_nxt;
      r_sold_out <= w_sold_nxt;
      if (w_accept) r_sel <= sel;
    end
  end

  // A vend and a restock hitting the same item cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ITEMS; i++) r_stock[i] <= STOCK_W'(STOCK_INIT);
    end else begin
      for (int i = 0; i < NUM_ITEMS; i++) begin
        if ((restock && restock_sel == SEL_W'(i)) && !(r_state == S_VEND && r_sel == SEL_W'(i)))
          r_stock[i] <= f_sat_inc(r_stock[i]);
        else if (!(restock && restock_sel == SEL_W'(i)) && (r_state == S_VEND && r_sel == SEL_W'(i)))
          r_stock[i] <= r_stock[i] - 1'b1;
      end
    end
  end

  assign done         = (r_state == S_VEND);
  assign product      = done ? r_sel : '0;
  assign sold_out     = r_sold_out;
  assign credit       = r_credit;
  assign change_valid = (r_state == S_CHANGE) || (r_state == S_REFUND);
  assign change_coin  = change_valid ? f_change_code(r_credit) : 2'b00;
  assign busy         = (r_state != S_IDLE);

endmodule
